// File: rtl/button_press_decoder_if.sv
// Button decoder bus: debounced level in, press/long/repeat pulses and held level out.
// master is the upstream/consumer side, slave is the decoder itself.
interface button_press_decoder_if;
    logic signal_f;
    logic press_o;
    logic long_o;
    logic repeat_o;
    logic held_o;

    modport master (output signal_f, input press_o, long_o, repeat_o, held_o);
    modport slave  (input signal_f, output press_o, long_o, repeat_o, held_o);
endinterface

// File: rtl/button_press_decoder.sv
// Classifies debounced presses as short or long and emits auto-repeat ticks while a
// long press is held. All outputs are registered single-cycle pulses except held_o.
module button_press_decoder #(
    parameter int CNT_W        = 16,
    parameter int LONG_COUNT   = 5000,
    parameter int REPEAT_COUNT = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    button_press_decoder_if.slave       bus
);

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2,
        LONG    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_COUNT);
    localparam logic [CNT_W-1:0] REP_CNT  = CNT_W'(REPEAT_COUNT);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_long;
    logic             r_repeat;
    logic             r_held;
    logic [CNT_W-1:0] w_cnt_inc;

    // cnt stays below max(LONG_COUNT, REPEAT_COUNT), so the increment never wraps
    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ARM;
            r_cnt    <= '0;
            r_press  <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_press  <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            case (r_state)
                ARM: begin
                    r_held <= 1'b0;
                    r_cnt  <= '0;
                    if (!bus.signal_f) r_state <= IDLE;
                end
                IDLE: begin
                    if (bus.signal_f) begin
                        r_state <= PRESSED;
                        r_cnt   <= CNT_W'(1);
                        r_held  <= 1'b1;
                    end else begin
                        r_held  <= 1'b0;
                    end
                end
                PRESSED: begin
                    if (bus.signal_f) begin
                        r_held <= 1'b1;
                        if (w_cnt_inc == LONG_CNT) begin
                            r_state <= LONG;
                            r_cnt   <= '0;
                            r_long  <= 1'b1;
                        end else begin
                            r_cnt   <= w_cnt_inc;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_held  <= 1'b0;
                        r_press <= 1'b1;
                    end
                end
                LONG: begin
                    if (bus.signal_f) begin
                        r_held <= 1'b1;
                        // REPEAT_COUNT == 0 parks cnt at zero and never ticks
                        if (REPEAT_COUNT != 0) begin
                            if (w_cnt_inc == REP_CNT) begin
                                r_cnt    <= '0;
                                r_repeat <= 1'b1;
                            end else begin
                                r_cnt    <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt <= '0;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_held  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ARM;
                    r_cnt   <= '0;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.press_o  = r_press;
    assign bus.long_o   = r_long;
    assign bus.repeat_o = r_repeat;
    assign bus.held_o   = r_held;

endmodule

// File: tb/tb_button_press_decoder.sv
// Scoreboarded bench: two decoders (repeat on / repeat off) share one randomized input;
// a run-length reference model predicts each cycle's outputs.
module tb_button_press_decoder;

    localparam int L  = 8;
    localparam int RA = 4;
    localparam int RB = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig = 1'b0;

    always #5 clk = ~clk;

    button_press_decoder_if ifa ();
    button_press_decoder_if ifb ();

    assign ifa.signal_f = sig;
    assign ifb.signal_f = sig;

    button_press_decoder #(.CNT_W(16), .LONG_COUNT(L), .REPEAT_COUNT(RA)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    button_press_decoder #(.CNT_W(16), .LONG_COUNT(L), .REPEAT_COUNT(RB)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    // expected {press, long, repeat, held} per sampled cycle
    logic [3:0] qa[$];
    logic [3:0] qb[$];
    int checks = 0;
    int fails  = 0;

    // reference model: armed = a low has been seen since reset, n = highs in current press
    bit armed = 1'b0;
    int n     = 0;

    function automatic logic [3:0] expect_hi(int cnt, int rep);
        logic lg, rp;
        lg = (cnt == L);
        rp = (rep != 0) && (cnt > L) && (((cnt - L) % rep) == 0);
        return {1'b0, lg, rp, 1'b1};
    endfunction

    task automatic step(input bit s, input bit r);
        logic [3:0] ea, eb;
        @(negedge clk);
        sig = s;
        rst = r;
        if (r) begin
            armed = 1'b0;
            n = 0;
            ea = 4'b0;
            eb = 4'b0;
        end else if (!armed) begin
            if (!s) armed = 1'b1;
            ea = 4'b0;
            eb = 4'b0;
        end else if (s) begin
            n++;
            ea = expect_hi(n, RA);
            eb = expect_hi(n, RB);
        end else begin
            ea = {(n > 0 && n < L), 3'b000};
            eb = ea;
            n = 0;
        end
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    task automatic run(input bit s, input int cnt);
        for (int i = 0; i < cnt; i++) step(s, 1'b0);
    endtask

    task automatic chk(input string name, input int cyc, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got {press,long,rep,held}=%b expected %b", name, cyc, act, exp);
        end
    endtask

    // monitor: compares every cycle the DUTs present after a sampled stimulus
    int cyc = 0;
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("dutA_rep4", cyc, {ifa.press_o, ifa.long_o, ifa.repeat_o, ifa.held_o}, e);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("dutB_rep0", cyc, {ifb.press_o, ifb.long_o, ifb.repeat_o, ifb.held_o}, e);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int len, gap;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        run(1'b0, 2);
        // short press
        run(1'b1, 3);  run(1'b0, 2);
        // long boundary
        run(1'b1, 7);  run(1'b0, 2);
        run(1'b1, 8);  run(1'b0, 2);
        // auto-repeat
        run(1'b1, 20); run(1'b0, 2);
        // held through reset
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        run(1'b1, 30); run(1'b0, 1);
        run(1'b1, 2);  run(1'b0, 2);
        // reset mid-hold at sample 10
        run(1'b1, 9);
        step(1'b1, 1'b1);
        run(1'b1, 5);  run(1'b0, 1);
        run(1'b1, 8);  run(1'b0, 2);
        // minimum press, then long hold (single long_o on the repeat-off unit)
        run(1'b1, 1);  run(1'b0, 2);
        run(1'b1, 50); run(1'b0, 1);
        // back-to-back presses
        run(1'b1, 2);  run(1'b0, 1);
        run(1'b1, 2);  run(1'b0, 1);
        // randomized presses with occasional resets
        for (int k = 0; k < 60; k++) begin
            len = $urandom_range(1, 30);
            gap = $urandom_range(1, 3);
            for (int j = 0; j < len; j++) step(1'b1, ($urandom_range(0, 39) == 0));
            for (int j = 0; j < gap; j++) step(1'b0, ($urandom_range(0, 39) == 0));
        end
        run(1'b0, 2);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
